// File: rtl/smart_led_rgb_pwm_pkg.sv
// Shared types and constants for the smart-LED colour capture / PWM slice.
package smart_led_rgb_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    FORWARD = 2'd2
  } led_state_e;

  localparam int DEF_COLOR_BITS = 8;
  localparam int FRAME_BITS     = 3 * DEF_COLOR_BITS;

  // Channel slots inside a frame: G arrives first, so it sits at the top.
  localparam int CH_G = 2;
  localparam int CH_R = 1;
  localparam int CH_B = 0;

  function automatic int frame_bits(input int color_bits);
    return 3 * color_bits;
  endfunction

endpackage

// File: rtl/smart_led_pwm_channel.sv
// One PWM lane: shadow duty reloaded only on counter wrap, registered compare.
// Optional square-law gamma on the shadow load when SMART_LED_GAMMA_EN is defined.
module smart_led_pwm_channel
  import smart_led_rgb_pwm_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLOR_BITS-1:0] count,
  input  logic                  wrap,
  input  logic [COLOR_BITS-1:0] color,
  output logic                  pwm
);

  logic [COLOR_BITS-1:0] duty;
  logic [COLOR_BITS-1:0] shadow;

`ifdef SMART_LED_GAMMA_EN
  logic [2*COLOR_BITS-1:0] color_ext;
  logic [2*COLOR_BITS-1:0] color_sq;
  assign color_ext = {{COLOR_BITS{1'b0}}, color};
  assign color_sq  = color_ext * color_ext;
  assign duty      = color_sq[2*COLOR_BITS-1:COLOR_BITS];
`else
  assign duty = color;
`endif

  // Reloading only at the wrap keeps every period glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wrap) shadow <= duty;
      pwm <= (count < shadow);
    end
  end

endmodule

// File: rtl/smart_led_rgb_pwm.sv
// Smart-LED receive tail: captures the first G,R,B frame, forwards later bits
// down the chain and drives three PWM outputs. Gamma option: SMART_LED_GAMMA_EN.
module smart_led_rgb_pwm
  import smart_led_rgb_pwm_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_clk,
  input  logic                  in_data,
  input  logic                  in_sync,
  output logic                  out_clk,
  output logic                  out_data,
  output logic                  frame_done,
  output logic [COLOR_BITS-1:0] color_g,
  output logic [COLOR_BITS-1:0] color_r,
  output logic [COLOR_BITS-1:0] color_b,
  output logic                  pwm_g,
  output logic                  pwm_r,
  output logic                  pwm_b
);

  localparam int FB = frame_bits(COLOR_BITS);
  localparam int CW = $clog2(FB + 1);

  led_state_e                   state, state_nxt;
  logic [FB-1:0]                shift;
  logic [CW-1:0]                bit_cnt;
  logic                         strobe_rx, last_bit, latch_pend;
  logic [2:0][COLOR_BITS-1:0]   color;
  logic [COLOR_BITS-1:0]        pwm_cnt;
  logic                         pwm_wrap;
  logic [2:0]                   pwm;

  assign strobe_rx = (state == RECEIVE) && in_clk;
  assign last_bit  = strobe_rx && (bit_cnt == CW'(FB - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_sync) state_nxt = RECEIVE;
      RECEIVE: begin
        // A final strobe coinciding with sync drop still completes the frame.
        if (last_bit)      state_nxt = in_sync ? FORWARD : IDLE;
        else if (!in_sync) state_nxt = IDLE;
      end
      FORWARD: if (!in_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (strobe_rx) begin
      shift   <= {shift[FB-2:0], in_data};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The packed colour array has the same G,R,B layout as the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_pend <= 1'b0;
      frame_done <= 1'b0;
      color      <= '0;
    end else begin
      latch_pend <= last_bit;
      frame_done <= latch_pend;
      if (latch_pend) color <= shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_clk  <= 1'b0;
      out_data <= 1'b0;
    end else begin
      out_clk <= (state == FORWARD) && in_clk;
      if ((state == FORWARD) && in_clk) out_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_wrap = &pwm_cnt;

  for (genvar i = 0; i < 3; i++) begin : g_ch
    smart_led_pwm_channel #(.COLOR_BITS(COLOR_BITS)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .count (pwm_cnt),
      .wrap  (pwm_wrap),
      .color (color[i]),
      .pwm   (pwm[i])
    );
  end

  assign color_g = color[CH_G];
  assign color_r = color[CH_R];
  assign color_b = color[CH_B];
  assign pwm_g   = pwm[CH_G];
  assign pwm_r   = pwm[CH_R];
  assign pwm_b   = pwm[CH_B];

endmodule

// File: tb/tb_smart_led_rgb_pwm.sv
// Directed bench for smart_led_rgb_pwm: frame-level model checked every cycle
// plus literal expectations on colours, pulse counts and PWM duty.
module tb_smart_led_rgb_pwm;

  logic       clk = 1'b0;
  logic       rst_n, in_clk, in_data, in_sync;
  logic       out_clk, out_data, frame_done;
  logic [7:0] color_g, color_r, color_b;
  logic       pwm_g, pwm_r, pwm_b;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  smart_led_rgb_pwm #(.COLOR_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_clk(in_clk), .in_data(in_data), .in_sync(in_sync),
    .out_clk(out_clk), .out_data(out_data), .frame_done(frame_done),
    .color_g(color_g), .color_r(color_r), .color_b(color_b),
    .pwm_g(pwm_g), .pwm_r(pwm_r), .pwm_b(pwm_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gam(input logic [7:0] c);
`ifdef SMART_LED_GAMMA_EN
    return 8'((int'(c) * int'(c)) / 256);
`else
    return c;
`endif
  endfunction

  // ---------------- behavioural model (index 0=B, 1=R, 2=G) ----------------
  int         m_phase;   // 0 waiting for sync, 1 collecting own frame, 2 passing bits on
  int         m_bits;
  logic [23:0] m_acc;
  bit         m_pend, m_done, m_oclk, m_odata;
  logic [7:0] m_col [3];
  logic [7:0] m_sh  [3];
  logic [2:0] m_pwm;
  int         m_cyc;     // cycles since reset release = PWM counter position

  task automatic model_reset();
    m_phase = 0; m_bits = 0; m_acc = '0; m_pend = 0; m_done = 0;
    m_oclk = 0; m_odata = 0; m_pwm = '0; m_cyc = 0;
    for (int c = 0; c < 3; c++) begin m_col[c] = '0; m_sh[c] = '0; end
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      m_pwm[c] = ((m_cyc % 256) < int'(m_sh[c]));
      if ((m_cyc % 256) == 255) m_sh[c] = gam(m_col[c]);
    end
    m_cyc++;
    m_done = m_pend;
    if (m_pend) for (int c = 0; c < 3; c++) m_col[c] = m_acc[c*8 +: 8];
    m_pend = 0;
    m_oclk = (m_phase == 2) && in_clk;
    if (m_oclk) m_odata = in_data;
    case (m_phase)
      0: if (in_sync) begin m_phase = 1; m_bits = 0; end
      1: begin
        if (in_clk) begin
          m_acc = {m_acc[22:0], in_data};
          m_bits++;
        end
        if (in_clk && m_bits == 24) begin
          m_pend  = 1;
          m_phase = in_sync ? 2 : 0;
        end else if (!in_sync) m_phase = 0;
      end
      default: if (!in_sync) m_phase = 0;
    endcase
  endtask

  int          done_cnt = 0, oclk_cnt = 0;
  logic [31:0] fw_bits  = '0;

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    chk("out_clk", {31'd0, out_clk}, {31'd0, m_oclk});
    if (m_oclk) chk("out_data", {31'd0, out_data}, {31'd0, m_odata});
    chk("colour", {8'd0, color_g, color_r, color_b}, {8'd0, m_col[2], m_col[1], m_col[0]});
    chk("pwm", {29'd0, pwm_g, pwm_r, pwm_b}, {29'd0, m_pwm});
    done_cnt += int'(frame_done);
    oclk_cnt += int'(out_clk);
    if (out_clk) fw_bits = {fw_bits[30:0], out_data};
    if (rst_n) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit drop_last);
    for (int i = n - 1; i >= 0; i--) begin
      in_clk = 1'b1; in_data = v[i];
      if (drop_last && i == 0) in_sync = 1'b0;
      tick();
      in_clk = 1'b0;
      tick();
    end
  endtask

  task automatic sync_up();
    in_sync = 1'b1; tick();
  endtask

  task automatic sync_down();
    in_sync = 1'b0; tick();
  endtask

  task automatic window(output int hg, output int hr, output int hb);
    hg = 0; hr = 0; hb = 0;
    repeat (256) begin tick(); hg += int'(pwm_g); hr += int'(pwm_r); hb += int'(pwm_b); end
  endtask

  int d0, o0, hg, hr, hb;

  initial begin
    rst_n = 1'b0; in_clk = 1'b0; in_data = 1'b0; in_sync = 1'b0;
    tick(3);
    chk("reset_colour", {8'd0, color_g, color_r, color_b}, 32'd0);
    chk("reset_ctl", {29'd0, out_clk, frame_done, pwm_b}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single frame, no forwarding
    d0 = done_cnt; o0 = oclk_cnt;
    sync_up();
    send_bits(32'hFF0080, 24, 1'b0);
    sync_down();
    tick(3);
    chk("t1_g", {24'd0, color_g}, 32'hFF);
    chk("t1_r", {24'd0, color_r}, 32'h00);
    chk("t1_b", {24'd0, color_b}, 32'h80);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_no_fwd", oclk_cnt - o0, 0);

    // frame then 24 forwarded bits; last one coincides with sync drop
    d0 = done_cnt; o0 = oclk_cnt;
    sync_up();
    send_bits(32'hFF0080, 24, 1'b0);
    send_bits(32'hA5A5A5, 24, 1'b1);
    tick(3);
    chk("t2_fwd_pulses", oclk_cnt - o0, 24);
    chk("t2_fwd_bits", {8'd0, fw_bits[23:0]}, 32'hA5A5A5);
    chk("t2_colour", {8'd0, color_g, color_r, color_b}, 32'hFF0080);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // final strobe together with sync drop still latches, then back to idle
    d0 = done_cnt; o0 = oclk_cnt;
    sync_up();
    send_bits(32'h0A0B0C, 24, 1'b1);
    send_bits(32'h1, 1, 1'b0);
    tick(3);
    chk("t3_colour", {8'd0, color_g, color_r, color_b}, 32'h0A0B0C);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_no_fwd", oclk_cnt - o0, 0);

    // partial frame discarded
    d0 = done_cnt;
    sync_up();
    send_bits(32'h2AB, 10, 1'b0);
    sync_down();
    tick(3);
    chk("t4_partial_done", done_cnt - d0, 0);
    chk("t4_partial_colour", {8'd0, color_g, color_r, color_b}, 32'h0A0B0C);
    sync_up();
    send_bits(32'h123440, 24, 1'b0);
    sync_down();
    tick(3);
    chk("t4_colour", {8'd0, color_g, color_r, color_b}, 32'h123440);

    // PWM duty: B=0x40 latched mid period
    tick(260);
    window(hg, hr, hb);
    chk("pwm_b_40", hb, int'(gam(8'h40)));
`ifndef SMART_LED_GAMMA_EN
    chk("pwm_b_40_lit", hb, 64);
`endif
    sync_up();
    send_bits(32'h008000, 24, 1'b0);
    sync_down();
    tick(260);
    window(hg, hr, hb);
    chk("pwm_b_00", hb, 0);
`ifdef SMART_LED_GAMMA_EN
    chk("pwm_r_80_gamma", hr, 64);
`else
    chk("pwm_r_80", hr, 128);
`endif
    chk("color_r_80", {24'd0, color_r}, 32'h80);
    sync_up();
    send_bits(32'h0000FF, 24, 1'b0);
    sync_down();
    tick(260);
    window(hg, hr, hb);
`ifdef SMART_LED_GAMMA_EN
    chk("pwm_b_ff_gamma", hb, 254);
`else
    chk("pwm_b_ff", hb, 255);
`endif

    // asynchronous reset during forwarding
    sync_up();
    send_bits(32'hFF0080, 24, 1'b0);
    send_bits(32'h5, 3, 1'b0);
    in_clk = 1'b1; in_data = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_reset", {13'd0, out_clk, out_data, frame_done, color_g, color_r, color_b, pwm_g, pwm_r, pwm_b}, 32'd0);
    in_clk = 1'b0; in_data = 1'b0; in_sync = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    sync_up();
    send_bits(32'h5A3C96, 24, 1'b0);
    sync_down();
    tick(3);
    chk("post_reset_colour", {8'd0, color_g, color_r, color_b}, 32'h5A3C96);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
